// File: rtl/mem_req_queue.sv
// In-order CPU request queue feeding a stalling memory port; one command per ISSUE, with a GAP cycle after each.
// Optional statistics outputs (StallCycles, ReqDone) are compiled in when MEMREQ_STATS_EN is defined.
module mem_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ReqValid,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              ReqReady,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              Busy,
  output logic              MemReadCpu,
  output logic              MemWriteCpu,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataIn,
  input  logic              Stall,
  input  logic [DATA_W-1:0] DataOut
`ifdef MEMREQ_STATS_EN
  ,
  output logic [15:0]       StallCycles,
  output logic [15:0]       ReqDone
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic                fifo_write_q [DEPTH];
  logic [ADDR_W-1:0]   fifo_addr_q  [DEPTH];
  logic [DATA_W-1:0]   fifo_data_q  [DEPTH];
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                push, pop, head_write;

  assign ReqReady   = (count_q != FULL_CNT);
  assign push       = ReqValid && ReqReady;
  assign pop        = (state_q == ISSUE) && !Stall;
  assign head_write = fifo_write_q[rd_ptr_q];
  assign Address    = fifo_addr_q[rd_ptr_q];
  assign DataIn     = fifo_data_q[rd_ptr_q];
  assign RspValid   = rsp_valid_q;
  assign RspData    = rsp_data_q;
  assign Busy       = (count_q != '0) || (state_q != IDLE);

  // Entries are cleared on reset so Address/DataIn read back as zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          fifo_write_q[gi] <= 1'b0;
          fifo_addr_q[gi]  <= '0;
          fifo_data_q[gi]  <= '0;
        end else if (push && (wr_ptr_q == AW'(gi))) begin
          fifo_write_q[gi] <= ReqWrite;
          fifo_addr_q[gi]  <= ReqAddr;
          fifo_data_q[gi]  <= ReqData;
        end
      end
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    MemReadCpu  = 1'b0;
    MemWriteCpu = 1'b0;
    case (state_q)
      IDLE:  if (count_q != '0) state_d = ISSUE;
      ISSUE: begin
        MemReadCpu  = !head_write;
        MemWriteCpu = head_write;
        if (!Stall) state_d = GAP;
      end
      // count_q here already reflects the pop taken on entry to GAP.
      GAP:     state_d = (count_q != '0) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rsp_valid_q <= pop && !head_write;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop && !head_write) rsp_data_q <= DataOut;
    end
  end

`ifdef MEMREQ_STATS_EN
  logic [15:0] stall_cycles_q, req_done_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cycles_q <= '0;
      req_done_q     <= '0;
    end else begin
      if ((state_q == ISSUE) && Stall && (stall_cycles_q != 16'hFFFF))
        stall_cycles_q <= stall_cycles_q + 1'b1;
      if (pop && (req_done_q != 16'hFFFF))
        req_done_q <= req_done_q + 1'b1;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign ReqDone     = req_done_q;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Scoreboard bench for mem_req_queue: a reference memory predicts load data at push time,
// a behavioural memory with programmable stall answers the DUT, and responses are popped and compared.
module tb_mem_req_queue;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [9:0]  ReqAddr = '0;
  logic [31:0] ReqData = '0;
  logic        ReqReady, RspValid, Busy, MemReadCpu, MemWriteCpu;
  logic [31:0] RspData, DataIn, DataOut;
  logic [9:0]  Address;
  logic        Stall;
`ifdef MEMREQ_STATS_EN
  logic [15:0] StallCycles, ReqDone;
`endif

  mem_req_queue #(.DEPTH(4), .ADDR_W(10), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .ReqReady(ReqReady), .RspValid(RspValid), .RspData(RspData), .Busy(Busy),
    .MemReadCpu(MemReadCpu), .MemWriteCpu(MemWriteCpu), .Address(Address), .DataIn(DataIn),
    .Stall(Stall), .DataOut(DataOut)
`ifdef MEMREQ_STATS_EN
    , .StallCycles(StallCycles), .ReqDone(ReqDone)
`endif
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int rsp_cnt  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mem_model [1024];
  logic [31:0] ref_mem   [1024];

  // Memory model: stalls stall_cfg edges per command, or indefinitely while stall_force is set.
  int   stall_cfg   = 0;
  int   stall_left  = 0;
  logic stall_force = 1'b0;
  logic cmd;
  assign cmd     = MemReadCpu | MemWriteCpu;
  assign Stall   = stall_force | (cmd & (stall_left != 0));
  assign DataOut = MemReadCpu ? mem_model[Address] : 32'hDEAD_BEEF;

  always @(posedge CLK) begin
    if (cmd && !Stall) begin
      stall_left <= stall_cfg;
      if (MemWriteCpu) mem_model[Address] <= DataIn;
    end else if (cmd && stall_left != 0) begin
      stall_left <= stall_left - 1;
    end else if (!cmd) begin
      stall_left <= stall_cfg;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge CLK) begin
    if (RST && RspValid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) check_eq("rsp_unexpected", RspValid, 0);
      else check_eq("rsp_data", RspData, exp_q.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with ReqValid still high.
  task automatic push_req(input logic wr, input logic [9:0] addr, input logic [31:0] data);
    int n = 0;
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqData = data;
    while (!ReqReady && n < 200) begin @(negedge CLK); n++; end
    if (!ReqReady) check_eq("push_ready_timeout", ReqReady, 1);
    if (wr) ref_mem[addr] = data;
    else    exp_q.push_back(ref_mem[addr]);
    $display("push %s addr=%03h data=%08h", wr ? "ST" : "LD", addr, data);
    @(negedge CLK);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    ReqValid = 1'b0;
    while ((Busy || exp_q.size() != 0) && n < 500) begin @(negedge CLK); n++; end
    check_eq({tag, "_busy"}, Busy, 0);
    check_eq({tag, "_outstanding"}, exp_q.size(), 0);
  endtask

  initial begin
    int n, rsp_before;
    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = 32'h1000_0000 + i;
      ref_mem[i]   = 32'h1000_0000 + i;
    end
    mem_model[4] = 32'hCAFE0001;
    ref_mem[4]   = 32'hCAFE0001;

    // Reset values
    repeat (2) @(negedge CLK);
    check_eq("rst_ready", ReqReady, 1);
    check_eq("rst_rspvalid", RspValid, 0);
    check_eq("rst_rspdata", RspData, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_rd", MemReadCpu, 0);
    check_eq("rst_wr", MemWriteCpu, 0);
    check_eq("rst_addr", Address, 0);
    check_eq("rst_datain", DataIn, 0);
`ifdef MEMREQ_STATS_EN
    check_eq("rst_stall_cycles", StallCycles, 0);
    check_eq("rst_req_done", ReqDone, 0);
`endif
    RST = 1'b1;
    @(negedge CLK);

    // Single load hit: exact cycle-by-cycle latency
    stall_cfg = 0;
    push_req(1'b0, 10'h004, 32'h0);
    ReqValid = 1'b0;
    check_eq("t1_idle_rd", MemReadCpu, 0);
    @(negedge CLK);
    check_eq("t1_issue_rd", MemReadCpu, 1);
    check_eq("t1_issue_addr", Address, 10'h004);
    @(negedge CLK);
    check_eq("t1_gap_rd", MemReadCpu, 0);
    check_eq("t1_rspvalid", RspValid, 1);
    check_eq("t1_rspdata", RspData, 32'hCAFE0001);
    @(negedge CLK);
    check_eq("t1_rsp_pulse", RspValid, 0);
    wait_drain("t1");

    // Store then load with 3 stall edges each
    stall_cfg = 3;
    rsp_before = rsp_cnt;
    push_req(1'b1, 10'h010, 32'hA5A5_0F0F);
    push_req(1'b0, 10'h010, 32'h0);
    ReqValid = 1'b0;
    n = 0;
    while (!MemWriteCpu && n < 20) begin @(negedge CLK); n++; end
    n = 0;
    while (MemWriteCpu && n < 20) begin
      check_eq("t2_datain_stable", DataIn, 32'hA5A5_0F0F);
      @(negedge CLK); n++;
    end
    check_eq("t2_write_cycles", n, 4);
    check_eq("t2_gap_rd", MemReadCpu, 0);
    @(negedge CLK);
    check_eq("t2_load_rd", MemReadCpu, 1);
    wait_drain("t2");
    check_eq("t2_rsp_count", rsp_cnt - rsp_before, 1);

    // Fill to full with stall held, fifth request held off
    stall_cfg = 0;
    stall_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_req(1'b0, 10'h040 + 10'(i), 32'h0);
      if (i == 2) check_eq("t3_ready_3", ReqReady, 1);
    end
    check_eq("t3_full", ReqReady, 0);
    ReqAddr = 10'h044;
    @(negedge CLK);
    check_eq("t3_full_hold", ReqReady, 0);
    stall_force = 1'b0;
    @(negedge CLK);
    check_eq("t3_ready_after_pop", ReqReady, 1);
    exp_q.push_back(ref_mem[10'h044]);
    @(negedge CLK);
    ReqValid = 1'b0;
    wait_drain("t3");

    // Mixed traffic with simultaneous push/pop and pointer wrap
    for (int r = 0; r < 2; r++) begin
      stall_cfg = r * 2;
      for (int i = 0; i < 10; i++)
        push_req(1'($urandom_range(0, 1)), 10'h020 + 10'($urandom_range(0, 7)), $urandom);
      wait_drain("t4");
    end

    // Asynchronous reset while issuing with entries queued
    stall_force = 1'b1;
    for (int i = 0; i < 4; i++) push_req(1'b0, 10'h050 + 10'(i), 32'h0);
    ReqValid = 1'b0;
    check_eq("t5_pre_rd", MemReadCpu, 1);
    #2 RST = 1'b0;
    #1;
    check_eq("t5_rd", MemReadCpu, 0);
    check_eq("t5_wr", MemWriteCpu, 0);
    check_eq("t5_busy", Busy, 0);
    check_eq("t5_ready", ReqReady, 1);
    exp_q.delete();
    rsp_before = rsp_cnt;
    @(negedge CLK);
    stall_force = 1'b0;
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    check_eq("t5_no_rsp", rsp_cnt - rsp_before, 0);
    check_eq("t5_idle", Busy, 0);

`ifdef MEMREQ_STATS_EN
    stall_cfg = 2;
    for (int i = 0; i < 3; i++) push_req(1'b0, 10'h060 + 10'(i), 32'h0);
    wait_drain("t6");
    check_eq("t6_req_done", ReqDone, 3);
    check_eq("t6_stall_cycles", StallCycles, 6);
    stall_force = 1'b1;
    push_req(1'b0, 10'h070, 32'h0);
    ReqValid = 1'b0;
    repeat (70000) @(negedge CLK);
    check_eq("t6_stall_sat", StallCycles, 16'hFFFF);
    stall_force = 1'b0;
    wait_drain("t6b");
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
